karatsuba_seq_mul: RTL and testbench

//  Multi-cycle N_BITS x N_BITS unsigned multiplier. It time-shares ONE combinational

---
 rtl/karatsuba_seq_mul.sv | 140 ++++++++++++++
 tb/tb_karatsuba_seq_mul.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_mul.sv
// karatsuba_seq_mul: multi-cycle unsigned multiplier sharing one Karatsuba core across three sub-products

// karatsuba_mul: combinational unsigned multiplier, one Karatsuba level for widths >= 4
module karatsuba_mul #(
  parameter int M = 9
) (
  input  logic [M-1:0]   x,
  input  logic [M-1:0]   y,
  output logic [2*M-1:0] p
);
  if (M < 4) begin : g_direct
    assign p = (2*M)'(x) * (2*M)'(y);
  end else begin : g_kara
    localparam int K = (M + 1) / 2;
    localparam int J = M / 2;
    logic [2*K-1:0] w_z0;
    logic [2*J-1:0] w_z2;
    logic [K:0]     w_sx;
    logic [K:0]     w_sy;
    logic [2*K+1:0] w_z3;
    logic [2*K+1:0] w_zm;
    assign w_z0 = (2*K)'(x[K-1:0]) * (2*K)'(y[K-1:0]);
    assign w_z2 = (2*J)'(x[M-1:K]) * (2*J)'(y[M-1:K]);
    assign w_sx = (K+1)'(x[K-1:0]) + (K+1)'(x[M-1:K]);
    assign w_sy = (K+1)'(y[K-1:0]) + (K+1)'(y[M-1:K]);
    assign w_z3 = (2*K+2)'(w_sx) * (2*K+2)'(w_sy);
    assign w_zm = w_z3 - (2*K+2)'(w_z0) - (2*K+2)'(w_z2);
    assign p = (2*M)'(w_z0) + ((2*M)'(w_zm) << K) + ((2*M)'(w_z2) << (2*K));
  end
endmodule

module karatsuba_seq_mul #(
  parameter int N_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_BITS-1:0]   c,
  output logic                  busy
);
  localparam int H  = (N_BITS + 1) / 2;
  localparam int L  = N_BITS / 2;
  localparam int M  = H + 1;
  localparam int CW = 2 * N_BITS;

  typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_MID, COMBINE, DONE} state_t;

  state_t          r_state;
  logic [N_BITS-1:0] r_a;
  logic [N_BITS-1:0] r_b;
  logic [2*H-1:0]  r_p0;
  logic [2*L-1:0]  r_p2;
  logic [2*M-1:0]  r_p3;
  logic [M-1:0]    w_a0;
  logic [M-1:0]    w_a1;
  logic [M-1:0]    w_b0;
  logic [M-1:0]    w_b1;
  logic [M-1:0]    w_sa;
  logic [M-1:0]    w_sb;
  logic [M-1:0]    w_x;
  logic [M-1:0]    w_y;
  logic [2*M-1:0]  w_p;
  logic [2*M-1:0]  w_mid;
  logic [CW-1:0]   w_c;

  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

  assign w_a0 = M'(r_a[H-1:0]);
  assign w_a1 = M'(r_a[N_BITS-1:H]);
  assign w_b0 = M'(r_b[H-1:0]);
  assign w_b1 = M'(r_b[N_BITS-1:H]);
  assign w_sa = w_a0 + w_a1;
  assign w_sb = w_b0 + w_b1;

  // operand mux steering the shared multiplier by sequencing state
  always_comb begin
    w_x = (r_state == MUL_LO) ? w_a0 : (r_state == MUL_HI) ? w_a1 : w_sa;
    w_y = (r_state == MUL_LO) ? w_b0 : (r_state == MUL_HI) ? w_b1 : w_sb;
  end

  karatsuba_mul #(.M(M)) u_mul (
    .x (w_x),
    .y (w_y),
    .p (w_p)
  );

  // middle term is p3-p0-p2 = a0*b1+a1*b0, always non-negative
  assign w_mid = r_p3 - (2*M)'(r_p0) - (2*M)'(r_p2);
  assign w_c   = CW'(r_p0) + (CW'(w_mid) << H) + (CW'(r_p2) << (2*H));

  // sequencer: capture, three shared products, recombine, hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_p0      <= '0;
      r_p2      <= '0;
      r_p3      <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_state <= MUL_LO;
        end
        MUL_LO: begin
          r_p0    <= w_p[2*H-1:0];
          r_state <= MUL_HI;
        end
        MUL_HI: begin
          r_p2    <= w_p[2*L-1:0];
          r_state <= MUL_MID;
        end
        MUL_MID: begin
          r_p3    <= w_p;
          r_state <= COMBINE;
        end
        COMBINE: begin
          c         <= w_c;
          out_valid <= 1'b1;
          r_state   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// tb_karatsuba_seq_mul: directed and random checks of karatsuba_seq_mul against a*b
module tb_karatsuba_seq_mul;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] a, b;
  logic [31:0] c;
  logic        v15, r15, ov15, or15, busy15;
  logic [14:0] a15, b15;
  logic [29:0] c15;
  logic        v5, r5, ov5, or5, busy5;
  logic [4:0]  a5, b5;
  logic [9:0]  c5;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_acc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  karatsuba_seq_mul #(.N_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .busy(busy)
  );
  karatsuba_seq_mul #(.N_BITS(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .in_valid(v15), .in_ready(r15),
    .a(a15), .b(b15), .out_valid(ov15), .out_ready(or15), .c(c15), .busy(busy15)
  );
  karatsuba_seq_mul #(.N_BITS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5),
    .a(a5), .b(b5), .out_valid(ov5), .out_ready(or5), .c(c5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one transaction on the 16-bit unit: accept, latency, optional backpressure, output handshake
  task automatic op16(input logic [15:0] x, input logic [15:0] y, input int hold, input bit pulse);
    int n;
    logic [31:0] e;
    e = 32'(x) * 32'(y);
    a = x;
    b = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("accept_ready", {63'b0, in_ready}, 64'd1);
    tick();
    if (last_acc >= 0) check("issue_interval", {63'b0, (cyc - last_acc) >= 5}, 64'd1);
    last_acc = cyc;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    check("busy_after_accept", {63'b0, busy}, 64'd1);
    check("ready_after_accept", {63'b0, in_ready}, 64'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      out_ready = 1'($urandom);
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("latency", 64'(n), 64'd4);
    check("product", {32'b0, c}, {32'b0, e});
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse ? 1'($urandom) : 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      check("hold_valid", {63'b0, out_valid}, 64'd1);
      check("hold_c", {32'b0, c}, {32'b0, e});
      check("hold_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_cleared", {63'b0, out_valid}, 64'd0);
    check("idle_ready", {63'b0, in_ready}, 64'd1);
    check("c_kept", {32'b0, c}, {32'b0, e});
  endtask

  // lockstep transaction on the 15-bit and 5-bit units
  task automatic op_small(input logic [14:0] x15, input logic [14:0] y15,
                          input logic [4:0] x5, input logic [4:0] y5);
    int n;
    a15 = x15; b15 = y15; a5 = x5; b5 = y5;
    v15 = 1'b1; v5 = 1'b1;
    n = 0;
    while (!(r15 && r5) && n < 20) begin tick(); n++; end
    tick();
    v15 = 1'b0; v5 = 1'b0;
    n = 0;
    while (!(ov15 && ov5) && n < 20) begin tick(); n++; end
    check("c15", {34'b0, c15}, 64'(30'(x15) * 30'(y15)));
    check("c5", {54'b0, c5}, 64'(10'(x5) * 10'(y5)));
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    v15 = 1'b0; or15 = 1'b1; a15 = '0; b15 = '0;
    v5 = 1'b0; or5 = 1'b1; a5 = '0; b5 = '0;
    repeat (3) tick();
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_c", {32'b0, c}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    op16(16'hFFFF, 16'hFFFF, 0, 1'b0);
    check("t1_const", {32'b0, c}, 64'h0000_0000_FFFE_0001);
    op16(16'h0000, 16'h1234, 0, 1'b0);
    check("t2_zero", {32'b0, c}, 64'd0);
    op16(16'h0001, 16'hBEEF, 0, 1'b0);
    check("t2_one", {32'b0, c}, 64'h0000_BEEF);
    op16(16'h1234, 16'h5678, 10, 1'b1);
    check("t3_const", {32'b0, c}, 64'h0626_0060);

    a = 16'hABCD; b = 16'h0123; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("pre_reset_busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_c", {32'b0, c}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    last_acc = -1;
    tick();
    op16(16'd3, 16'd5, 0, 1'b0);
    check("t4_const", {32'b0, c}, 64'd15);

    op_small(15'h7FFF, 15'h7FFF, 5'd31, 5'd31);
    check("t5_const15", {34'b0, c15}, 64'h3FFF_0001);
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] ab;
      ab = 10'(i);
      op_small(15'($urandom), 15'($urandom), ab[9:5], ab[4:0]);
    end

    for (int i = 0; i < 2000; i++)
      op16(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
